// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Holds the pipeline via stall_req_o while working and emits a one-cycle done_o with the result.
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [2:0]       op_reg;
    logic             neg_reg;
    logic             rem_neg_reg;
    logic [XLEN-1:0]  mag_b_reg;
    logic [XLEN-1:0]  hi_reg;
    logic [XLEN-1:0]  lo_reg;
    logic [4:0]       rd_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [XLEN-1:0]  result_reg;
    logic [4:0]       rd_out_reg;

    // Operand decode at the accept point
    logic            signed_a_in, signed_b_in;
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            div_zero_in, overflow_in, special_in;
    logic [XLEN-1:0] special_res_in;
    logic            accept;

    always_comb begin
        signed_a_in = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                      (op_i == OP_DIV)  || (op_i == OP_REM);
        signed_b_in = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg_in    = signed_a_in & a_i[XLEN-1];
        b_neg_in    = signed_b_in & b_i[XLEN-1];
        a_mag_in    = a_neg_in ? (~a_i + 1'b1) : a_i;
        b_mag_in    = b_neg_in ? (~b_i + 1'b1) : b_i;
        div_zero_in = op_i[2] && (b_i == '0);
        overflow_in = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                      (a_i == MIN_NEG) && (b_i == '1);
        special_in  = div_zero_in || overflow_in;
        // op_i[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero_in) begin
            special_res_in = op_i[1] ? a_i : '1;
        end else begin
            special_res_in = op_i[1] ? '0 : a_i;
        end
    end

    assign accept = (state_reg == IDLE) && start_i && !flush_i;

    // One radix-2 step; multiply and divide share the hi/lo pair
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ok;
    logic [XLEN-1:0] hi_step, lo_step;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mag_b_reg} : '0);
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b_reg};
        div_ok    = !div_diff[XLEN];
        if (op_reg[2]) begin
            hi_step = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_step = {lo_reg[XLEN-2:0], div_ok};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    // Sign fix-up of the finished magnitudes
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_raw = {hi_step, lo_step};
        prod_fix = neg_reg ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix  = neg_reg ? (~lo_step + 1'b1) : lo_step;
        rem_fix  = rem_neg_reg ? (~hi_step + 1'b1) : hi_step;
        if (op_reg[2]) begin
            final_res = op_reg[1] ? rem_fix : quo_fix;
        end else if (op_reg == OP_MUL) begin
            final_res = prod_fix[XLEN-1:0];
        end else begin
            final_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == BUSY);
            done_reg  <= (state_next == DONE);
        end
    end

    // FSM next state
    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_next = special_in ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == LAST_STEP) begin
                        state_next = DONE;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        stall_req_o = accept || (state_reg == BUSY);
        busy_o      = busy_reg;
        done_o      = done_reg;
        result_o    = result_reg;
        rd_addr_o   = rd_out_reg;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg      <= '0;
            neg_reg     <= 1'b0;
            rem_neg_reg <= 1'b0;
            mag_b_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            rd_reg      <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            rd_out_reg  <= '0;
        end else if (flush_i) begin
            cnt_reg <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
        end else if (accept) begin
            op_reg      <= op_i;
            neg_reg     <= a_neg_in ^ b_neg_in;
            rem_neg_reg <= a_neg_in;
            mag_b_reg   <= b_mag_in;
            hi_reg      <= '0;
            lo_reg      <= a_mag_in;
            rd_reg      <= rd_addr_i;
            cnt_reg     <= '0;
            if (special_in) begin
                result_reg <= special_res_in;
                rd_out_reg <= rd_addr_i;
            end
        end else if (state_reg == BUSY) begin
            hi_reg  <= hi_step;
            lo_reg  <= lo_step;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_STEP) begin
                result_reg <= final_res;
                rd_out_reg <= rd_reg;
            end
        end
    end

endmodule
